// File: rtl/wb_region_decoder.sv
`default_nettype none
// wb_region_decoder: Wishbone classic address decoder with transfer supervision,
// error-ack for unmapped addresses, slave timeout and sticky fault logging.  Rev 1.0
module wb_region_decoder #(
   parameter int                                  ADDR_WIDTH     = 16,
   parameter int                                  NUM_SLAVES     = 4,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]    REGION_BASE    = {16'h5000, 16'h4000, 16'h3000, 16'h2000},
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]    REGION_MASK    = {4{16'hF000}},
   parameter int                                  TIMEOUT_CYCLES = 255
) (
   input  logic                    CLK_I,
   input  logic                    RST_N_I,
   input  logic [ADDR_WIDTH-1:0]   ADR_I,
   input  logic                    CYC_I,
   input  logic                    STB_I,
   input  logic [NUM_SLAVES-1:0]   SACK_I,
   output logic [NUM_SLAVES-1:0]   ACMP_O,
   output logic                    ACK_O,
   output logic                    ERR_O,
   output logic                    BUSY_O,
   output logic [ADDR_WIDTH-1:0]   ERR_ADR_O,
   output logic [1:0]              ERR_CAUSE_O
);

   localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST =
      CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                  state;
   logic [CNT_WIDTH-1:0]    count;
   logic [ADDR_WIDTH-1:0]   adr_lat;
   logic                    hit;
   logic [NUM_SLAVES-1:0]   hit_onehot;
   logic                    sel_ack;
   logic                    timed_out;

   // Scan from the top slot down so the lowest matching index is the one kept.
   always_comb begin
      hit        = 1'b0;
      hit_onehot = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((ADR_I & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
             (REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
            hit        = 1'b1;
            hit_onehot = NUM_SLAVES'(1) << i;
         end
      end
   end

   assign sel_ack   = |(SACK_I & ACMP_O);
   assign timed_out = (TIMEOUT_CYCLES != 0) && (count == CNT_LAST);

   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         state       <= ST_IDLE;
         count       <= '0;
         adr_lat     <= '0;
         ACMP_O      <= '0;
         ACK_O       <= 1'b0;
         ERR_O       <= 1'b0;
         BUSY_O      <= 1'b0;
         ERR_ADR_O   <= '0;
         ERR_CAUSE_O <= 2'b00;
      end else begin
         ACK_O <= 1'b0;
         ERR_O <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (CYC_I && STB_I) begin
                  adr_lat <= ADR_I;
                  BUSY_O  <= 1'b1;
                  if (hit) begin
                     state  <= ST_WAIT;
                     ACMP_O <= hit_onehot;
                     count  <= '0;
                  end else begin
                     state       <= ST_RESP;
                     ERR_O       <= 1'b1;
                     ERR_CAUSE_O <= 2'b01;
                     ERR_ADR_O   <= ADR_I;
                  end
               end
            end
            ST_WAIT: begin
               // Master abort outranks everything; an ack outranks a same-cycle timeout.
               if (!CYC_I) begin
                  state  <= ST_IDLE;
                  ACMP_O <= '0;
                  BUSY_O <= 1'b0;
               end else if (sel_ack) begin
                  state  <= ST_RESP;
                  ACMP_O <= '0;
                  ACK_O  <= 1'b1;
               end else if (timed_out) begin
                  state       <= ST_RESP;
                  ACMP_O      <= '0;
                  ERR_O       <= 1'b1;
                  ERR_CAUSE_O <= 2'b10;
                  ERR_ADR_O   <= adr_lat;
               end else if (count != '1) begin
                  count <= count + CNT_WIDTH'(1);
               end
            end
            ST_RESP: begin
               state  <= ST_IDLE;
               BUSY_O <= 1'b0;
            end
            default: begin
               state  <= ST_IDLE;
               ACMP_O <= '0;
               BUSY_O <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
